reg_busy_sched: RTL and testbench

- Dispatch-side register hazard scheduler for the in-order pipeline.
- Keeps a per-architectural-register count of in-flight writes. Count increments when a uop dispatches out of DE1 and decrements when the uop writes back at RB1.
- Gates dispatch with a stall whenever a source register has a pending write or a destination counter would overflow.
- Supports a drain request (hold dispatch until every count is zero) and a flush (clear all tracking).

---
 rtl/reg_busy_sched.sv | 127 ++++++++++++
 tb/tb_reg_busy_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_busy_sched.sv
// Dispatch-side register hazard scheduler: tracks in-flight writes per architectural
// register and stalls DE1 on RAW hazards, counter saturation, drain and flush.
module reg_busy_sched #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    localparam int REG_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                disp_valid,
    input  logic                disp_rs1_en,
    input  logic [REG_W-1:0]    disp_rs1,
    input  logic                disp_rs2_en,
    input  logic [REG_W-1:0]    disp_rs2,
    input  logic                disp_rd_en,
    input  logic [REG_W-1:0]    disp_rd,
    output logic                stall,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_rd,
    input  logic                drain_req,
    output logic                drained,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_mask
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt [NUM_REGS];

    logic                hz;
    logic                accept;
    logic                inc, dec;
    logic [NUM_REGS-1:0] inc_vec, dec_vec;
    logic                all_zero;

    // Register 0 is never tracked, so its enables are masked before any lookup.
    always_comb begin
        hz = 1'b0;
        if (disp_rs1_en && disp_rs1 != '0 && cnt[disp_rs1] != '0)
            hz = 1'b1;
        if (disp_rs2_en && disp_rs2 != '0 && cnt[disp_rs2] != '0)
            hz = 1'b1;
        if (disp_rd_en && disp_rd != '0 && cnt[disp_rd] == CNT_MAX)
            hz = 1'b1;
    end

    assign stall  = disp_valid & (hz | (state != ST_RUN) | flush);
    assign accept = disp_valid & ~stall;
    assign inc    = accept & disp_rd_en & (disp_rd != '0);
    assign dec    = wb_valid & (wb_rd != '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        inc_vec = '0;
        dec_vec = '0;
        if (inc)
            inc_vec[disp_rd] = 1'b1;
        if (dec)
            dec_vec[wb_rd] = 1'b1;
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            busy_mask[r] = (cnt[r] != '0);
    end

    assign all_zero = ~|busy_mask;
    assign drained  = (state == ST_DRAIN) & all_zero;

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = ST_FLUSH;
        else if (drain_req)
            state_nxt = ST_DRAIN;
        else
            state_nxt = ST_RUN;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // Simultaneous inc and dec on one register cancel; a dec at zero is absorbed.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            // NOTE: the counter array is reset explicitly because stale counts would stall forever.
            if (reset || flush)
                cnt[r] <= '0;
            else if (inc_vec[r] && !dec_vec[r])
                cnt[r] <= cnt[r] + 1'b1;
            else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
                cnt[r] <= cnt[r] - 1'b1;
        end
    end

`ifdef ASSERT
    always_ff @(posedge clk) begin
        if (!reset && !flush && dec)
            assert (cnt[wb_rd] != '0)
            else $error("reg_busy_sched: writeback to r%0d with no pending write", wb_rd);
    end
`endif

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_RUN && state_nxt == ST_DRAIN)
                $display("reg_busy_sched: RUN -> DRAIN at %0t", $time);
            if (state == ST_DRAIN && state_nxt == ST_RUN)
                $display("reg_busy_sched: DRAIN -> RUN at %0t", $time);
            if (state_nxt == ST_FLUSH)
                $display("reg_busy_sched: entering FLUSH at %0t", $time);
        end
    end
`endif

endmodule

// File: tb/tb_reg_busy_sched.sv
// Directed bench for reg_busy_sched: RAW, saturation, inc/dec cancel, r0, drain, flush.
module tb_reg_busy_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_valid, disp_rs1_en, disp_rs2_en, disp_rd_en;
    logic [4:0]  disp_rs1, disp_rs2, disp_rd;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        drain_req, drained, flush;
    logic [31:0] busy_mask;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_busy_sched #(.NUM_REGS(32), .CNT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .disp_valid (disp_valid),
        .disp_rs1_en(disp_rs1_en),
        .disp_rs1   (disp_rs1),
        .disp_rs2_en(disp_rs2_en),
        .disp_rs2   (disp_rs2),
        .disp_rd_en (disp_rd_en),
        .disp_rd    (disp_rd),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .drain_req  (drain_req),
        .drained    (drained),
        .flush      (flush),
        .busy_mask  (busy_mask)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        disp_valid = 0; disp_rs1_en = 0; disp_rs2_en = 0; disp_rd_en = 0;
        disp_rs1 = 0; disp_rs2 = 0; disp_rd = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic disp_rd_only(input logic [4:0] rd);
        disp_valid = 1; disp_rs1_en = 0; disp_rs2_en = 0;
        disp_rd_en = 1; disp_rd = rd;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1; wb_rd = rd;
    endtask

    initial begin
        idle();
        drain_req = 0;
        reset = 1;
        tick();
        tick();
        check("rst_busy", busy_mask, 32'h0);
        check("rst_drained", {31'b0, drained}, 32'd0);
        reset = 0;
        tick();
        check("idle_stall", {31'b0, stall}, 32'd0);

        // RAW hazard on r5
        disp_rd_only(5'd5);
        settle();
        check("raw_first_stall", {31'b0, stall}, 32'd0);
        tick();
        disp_rd_en = 0; disp_rs1_en = 1; disp_rs1 = 5'd5;
        settle();
        check("raw_stall", {31'b0, stall}, 32'd1);
        check("raw_busy", busy_mask, 32'h0000_0020);
        wb(5'd5);
        settle();
        check("raw_no_bypass", {31'b0, stall}, 32'd1);
        tick();
        wb_valid = 0;
        settle();
        check("raw_release", {31'b0, stall}, 32'd0);
        check("raw_busy_clr", busy_mask, 32'h0);
        tick();
        idle();

        // Saturation on r7
        for (int i = 0; i < 3; i++) begin
            disp_rd_only(5'd7);
            settle();
            check($sformatf("sat_acc%0d", i), {31'b0, stall}, 32'd0);
            tick();
        end
        check("sat_busy", busy_mask, 32'h0000_0080);
        settle();
        check("sat_fourth_stall", {31'b0, stall}, 32'd1);
        wb(5'd7);
        tick();
        wb_valid = 0;
        settle();
        check("sat_fourth_go", {31'b0, stall}, 32'd0);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            wb(5'd7);
            tick();
        end
        wb_valid = 0;
        settle();
        check("sat_still_one", busy_mask, 32'h0000_0080);
        wb(5'd7);
        tick();
        idle();
        settle();
        check("sat_empty", busy_mask, 32'h0);

        // Simultaneous inc/dec on r3
        disp_rd_only(5'd3);
        tick();
        disp_rd_only(5'd3);
        wb(5'd3);
        settle();
        check("incdec_stall", {31'b0, stall}, 32'd0);
        tick();
        idle();
        settle();
        check("incdec_busy", busy_mask, 32'h0000_0008);
        wb(5'd3);
        tick();
        idle();
        settle();
        check("incdec_zero", busy_mask, 32'h0);

        // Register 0 is never tracked
        for (int i = 0; i < 3; i++) begin
            disp_rd_only(5'd0);
            disp_rs1_en = 1; disp_rs1 = 5'd0;
            wb(5'd0);
            settle();
            check($sformatf("r0_stall%0d", i), {31'b0, stall}, 32'd0);
            tick();
            check($sformatf("r0_busy%0d", i), busy_mask, 32'h0);
        end
        idle();

        // Drain with r2 and r9 pending
        disp_rd_only(5'd2);
        tick();
        disp_rd_only(5'd9);
        tick();
        idle();
        drain_req = 1;
        tick();
        disp_valid = 1;
        settle();
        check("drain_stall", {31'b0, stall}, 32'd1);
        check("drain_pending", {31'b0, drained}, 32'd0);
        wb(5'd2);
        tick();
        check("drain_one_left", {31'b0, drained}, 32'd0);
        wb(5'd9);
        tick();
        wb_valid = 0;
        settle();
        check("drain_done", {31'b0, drained}, 32'd1);
        check("drain_done_stall", {31'b0, stall}, 32'd1);
        drain_req = 0;
        tick();
        check("drain_exit_stall", {31'b0, stall}, 32'd0);
        check("drain_exit_drained", {31'b0, drained}, 32'd0);
        idle();
        tick();

        // Flush mid-operation: r4=2, r6=1
        disp_rd_only(5'd4);
        tick();
        disp_rd_only(5'd4);
        tick();
        disp_rd_only(5'd6);
        tick();
        idle();
        settle();
        check("flush_pre_busy", busy_mask, 32'h0000_0050);
        disp_rd_only(5'd8);
        wb(5'd4);
        flush = 1;
        settle();
        check("flush_stall", {31'b0, stall}, 32'd1);
        tick();
        flush = 0; wb_valid = 0;
        settle();
        check("flush_busy", busy_mask, 32'h0);
        check("flush_state_stall", {31'b0, stall}, 32'd1);
        check("flush_drained", {31'b0, drained}, 32'd0);
        tick();
        check("flush_run_stall", {31'b0, stall}, 32'd0);
        tick();
        idle();
        settle();
        check("flush_post_acc", busy_mask, 32'h0000_0100);

        // Reset alongside flush: reset wins, FSM in RUN
        reset = 1; flush = 1; drain_req = 1;
        tick();
        reset = 0; flush = 0; drain_req = 0;
        disp_valid = 1;
        settle();
        check("rstflush_busy", busy_mask, 32'h0);
        check("rstflush_drained", {31'b0, drained}, 32'd0);
        check("rstflush_stall", {31'b0, stall}, 32'd0);
        tick();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
